seq_test_ctrl: RTL and testbench

Controller that sequences the sequence-detector datapath (one-hot and binary Moore FSMs sharing one serial input `w`). It replays a loaded bit pattern into the shared `w` line, emits one-cycle clock enables and a start-of-run reset to both FSMs, and samples their `z` outputs after every step. It counts detections, flags any disagreement between the two encodings, and reports the first mismatching step index. The block sits between the board top level and the two FSM instances, replacing the hand-toggled switch/button stimulus.

---
 rtl/seq_test_ctrl.sv | 132 +++++++++++++
 tb/tb_seq_test_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_test_ctrl.sv
// seq_test_ctrl: replays a loaded bit pattern into the shared serial input of
// the one-hot and binary sequence-detector FSMs. It issues their clock enable
// and start-of-run reset, then compares their z outputs after every step.
module seq_test_ctrl #(
  parameter int PAT_W    = 16,
  parameter int STEP_DIV = 4,
  parameter int CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [PAT_W-1:0]           pattern,
  input  logic [$clog2(PAT_W):0]     len,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       z_onehot,
  input  logic                       z_binary,
  output logic                       w,
  output logic                       fsm_ce,
  output logic                       fsm_rst,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           det_count,
  output logic [CNT_W-1:0]           mis_count,
  output logic [$clog2(PAT_W)-1:0]   mis_idx,
  output logic [2:0]                 dbgState
);

  localparam int LEN_W = $clog2(PAT_W) + 1;
  localparam int IDX_W = $clog2(PAT_W);
  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RST    = 3'd1,
    DRIVE  = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state, stateNext;
  logic [PAT_W-1:0]  patReg;
  logic [LEN_W-1:0]  lenReg;
  logic [LEN_W-1:0]  idx;
  logic [LEN_W-1:0]  idxInc;
  logic [DIV_W-1:0]  div;

  // Control protocol: load/start/abort are single-cycle level requests sampled
  // on the rising edge; abort wins over load, load wins over start, and
  // load/start are only honoured while not busy (IDLE or DONE).

  assign idxInc   = idx + LEN_W'(1);
  assign dbgState = state;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state selection; a zero-length run skips straight to DONE.
  always_comb begin
    stateNext = state;
    if (abort) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (load)       stateNext = IDLE;
          else if (start) stateNext = (lenReg == '0) ? DONE : RST;
        end
        RST:     stateNext = DRIVE;
        DRIVE:   if (div == DIV_LAST) stateNext = SAMPLE;
        SAMPLE:  stateNext = (idxInc == lenReg) ? DONE : DRIVE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state only, so none depend on inputs.
  always_comb begin
    busy    = (state == RST) || (state == DRIVE) || (state == SAMPLE);
    done    = (state == DONE);
    fsm_rst = (state == RST);
    fsm_ce  = (state == DRIVE) && (div == DIV_LAST);
    w       = 1'b0;
    if ((state == DRIVE) || (state == SAMPLE)) w = patReg[idx[IDX_W-1:0]];
  end

  // Pattern capture, step/divider counters and result accumulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      patReg    <= '0;
      lenReg    <= '0;
      idx       <= '0;
      div       <= '0;
      det_count <= '0;
      mis_count <= '0;
      mis_idx   <= '0;
    end else if (!abort) begin
      case (state)
        IDLE, DONE: begin
          if (load) begin
            patReg <= pattern;
            lenReg <= (len > LEN_MAX) ? LEN_MAX : len;
          end else if (start) begin
            det_count <= '0;
            mis_count <= '0;
            mis_idx   <= '0;
            idx       <= '0;
          end
        end
        RST:   div <= '0;
        DRIVE: div <= div + DIV_W'(1);
        SAMPLE: begin
          if (z_onehot && (det_count != CNT_MAX)) det_count <= det_count + CNT_W'(1);
          if (z_onehot != z_binary) begin
            if (mis_count != CNT_MAX) mis_count <= mis_count + CNT_W'(1);
            if (mis_count == '0)      mis_idx   <= idx[IDX_W-1:0];
          end
          idx <= idxInc;
          div <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_test_ctrl.sv
// Bench for seq_test_ctrl: two instances (8-bit and 2-bit counters) share the
// control inputs; each drives a stand-in FSM pair where z is w registered on
// fsm_ce. The binary stand-in of the main instance inverts z at chosen steps.
module tb_seq_test_ctrl;

  localparam int STEP_CYC = 5;  // STEP_DIV + 1 cycles per step

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0]  len = '0;

  logic        zOh, zBin, w, fsm_ce, fsm_rst, busy, done;
  logic [7:0]  det_count, mis_count;
  logic [3:0]  mis_idx;
  logic [2:0]  dbgState;

  logic        zOh2, w2, fsm_ce2, fsm_rst2, busy2, done2;
  logic [1:0]  det2, mis2;
  logic [3:0]  misIdx2;
  logic [2:0]  dbgState2;

  logic [15:0] faultMask = '0;
  logic [4:0]  stepK;
  int          ceTotal = 0;

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  typedef struct {
    string       name;
    logic [15:0] pat;
    logic [4:0]  len;
    logic [15:0] mask;
    int          steps;
    int          expDet;
    int          expMis;
    int          expIdx;
  } vec_t;

  vec_t vecs[7];

  seq_test_ctrl dut (
    .clk(clk), .reset(reset), .load(load), .pattern(pattern), .len(len),
    .start(start), .abort(abort), .z_onehot(zOh), .z_binary(zBin),
    .w(w), .fsm_ce(fsm_ce), .fsm_rst(fsm_rst), .busy(busy), .done(done),
    .det_count(det_count), .mis_count(mis_count), .mis_idx(mis_idx),
    .dbgState(dbgState)
  );

  seq_test_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .load(load), .pattern(pattern), .len(len),
    .start(start), .abort(abort), .z_onehot(zOh2), .z_binary(zOh2),
    .w(w2), .fsm_ce(fsm_ce2), .fsm_rst(fsm_rst2), .busy(busy2), .done(done2),
    .det_count(det2), .mis_count(mis2), .mis_idx(misIdx2),
    .dbgState(dbgState2)
  );

  // Clock.
  always #5 clk = ~clk;

  // Stand-in FSM pair for the main instance.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      zOh <= 1'b0; zBin <= 1'b0; stepK <= '0;
    end else if (fsm_rst) begin
      zOh <= 1'b0; zBin <= 1'b0; stepK <= '0;
    end else if (fsm_ce) begin
      zOh   <= w;
      zBin  <= w ^ faultMask[stepK[3:0]];
      stepK <= stepK + 5'd1;
    end
  end

  // Stand-in FSMs for the saturation instance (both encodings agree).
  always @(posedge clk or negedge reset) begin
    if (!reset)        zOh2 <= 1'b0;
    else if (fsm_rst2) zOh2 <= 1'b0;
    else if (fsm_ce2)  zOh2 <= w2;
  end

  // Running count of enable pulses, read between edges.
  always @(posedge clk) if (fsm_ce) ceTotal <= ceTotal + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: results follow directly from the pattern bits and fault steps.
  function automatic void refModel(input logic [15:0] pat, input logic [4:0] l,
                                   input logic [15:0] mask, output int eff,
                                   output int det, output int mis, output int idx);
    eff = (l > 5'd16) ? 16 : int'(l);
    det = 0; mis = 0; idx = 0;
    for (int i = 0; i < eff; i++) begin
      det += int'(pat[i]);
      if (mask[i]) begin
        if (mis == 0) idx = i;
        mis++;
      end
    end
  endfunction

  task automatic loadPat(input logic [15:0] p, input logic [4:0] l, input logic withStart);
    pattern = p; len = l; load = 1'b1; start = withStart;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
  endtask

  task automatic runAndCheck(input string name, input logic [15:0] p, input int eff,
                             input int expDet, input int expMis, input int expIdx);
    int m, ceN, rstN, expDone, ceAt;
    logic [0:0] expBit;
    exp_q.delete();
    for (int i = 0; i < eff; i++) exp_q.push_back(p[i]);
    expDone = (eff == 0) ? 0 : 1 + eff * STEP_CYC;
    expBit = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m = 0; ceN = 0; rstN = 0; ceAt = -10;
    while (!done && m < 200) begin
      if (fsm_rst) rstN++;
      if (m == ceAt + 1) check({name, " w_hold"}, w, expBit);
      if (fsm_ce) begin
        check({name, " ce_slot"}, m, 4 + ceN * STEP_CYC);
        if (exp_q.size() == 0) begin
          check({name, " ce_extra"}, ceN + 1, eff);
        end else begin
          expBit = exp_q.pop_front();
          check({name, " w_at_ce"}, w, expBit);
        end
        ceAt = m;
        ceN++;
      end
      @(negedge clk);
      m++;
    end
    check({name, " done_cycle"}, m, expDone);
    check({name, " ce_count"}, ceN, eff);
    check({name, " rst_pulses"}, rstN, (eff == 0) ? 0 : 1);
    check({name, " busy_at_done"}, busy, 0);
    check({name, " det_count"}, det_count, expDet);
    check({name, " mis_count"}, mis_count, expMis);
    if (expMis != 0) check({name, " mis_idx"}, mis_idx, expIdx);
    check({name, " det_sat"}, det2, (expDet > 3) ? 3 : expDet);
    check({name, " mis_sat"}, mis2, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int eff, det, mis, idx, ceBefore;
    logic [15:0] rp, rm;
    logic [4:0]  rl;

    vecs[0] = '{"a5a5_clean", 16'hA5A5, 5'd16, 16'h0000, 16, 8, 0, 0};
    vecs[1] = '{"a5a5_fault", 16'hA5A5, 5'd16, 16'h0220, 16, 8, 2, 5};
    vecs[2] = '{"len0",       16'h1234, 5'd0,  16'h0000, 0,  0, 0, 0};
    vecs[3] = '{"clamp20",    16'h00FF, 5'd20, 16'h0000, 16, 8, 0, 0};
    vecs[4] = '{"single",     16'h0001, 5'd1,  16'h0001, 1,  1, 1, 0};
    vecs[5] = '{"last_bit",   16'h8000, 5'd16, 16'h8000, 16, 1, 1, 15};
    vecs[6] = '{"all_ones",   16'hFFFF, 5'd16, 16'h0000, 16, 16, 0, 0};

    // Reset block.
    repeat (3) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst w", w, 0);
    check("rst ce", fsm_ce, 0);
    check("rst fsm_rst", fsm_rst, 0);
    check("rst det", det_count, 0);
    check("rst mis", mis_count, 0);
    check("rst mis_idx", mis_idx, 0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst busy", busy, 0);

    // Directed table.
    foreach (vecs[i]) begin
      faultMask = vecs[i].mask;
      loadPat(vecs[i].pat, vecs[i].len, 1'b0);
      runAndCheck(vecs[i].name, vecs[i].pat, vecs[i].steps,
                  vecs[i].expDet, vecs[i].expMis, vecs[i].expIdx);
    end

    // Randomized runs against the reference model.
    for (int r = 0; r < 8; r++) begin
      rp = 16'($urandom);
      rm = 16'($urandom);
      rl = 5'($urandom_range(0, 20));
      refModel(rp, rl, rm, eff, det, mis, idx);
      faultMask = rm;
      loadPat(rp, rl, 1'b0);
      runAndCheck("random", rp, eff, det, mis, idx);
    end

    // load and start together: load wins, block stays idle, later start works.
    faultMask = '0;
    loadPat(16'hA5A5, 5'd16, 1'b1);
    check("load_start busy", busy, 0);
    check("load_start done", done, 0);
    runAndCheck("after_load_start", 16'hA5A5, 16, 8, 0, 0);

    // abort in the 4th SAMPLE cycle keeps the partial detection count.
    loadPat(16'hA5A5, 5'd16, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("abort pre busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort det", det_count, 2);
    ceBefore = ceTotal;
    repeat (10) @(negedge clk);
    check("abort ce_silent", ceTotal, ceBefore);
    check("abort idle", busy, 0);

    // Asynchronous reset part-way through the 4th step's DRIVE phase.
    loadPat(16'hFFFF, 5'd16, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    check("midrun busy", busy, 1);
    check("midrun det", det_count, 3);
    #2 reset = 1'b0;
    #1;
    check("async busy", busy, 0);
    check("async done", done, 0);
    check("async w", w, 0);
    check("async ce", fsm_ce, 0);
    check("async fsm_rst", fsm_rst, 0);
    check("async det", det_count, 0);
    check("async mis", mis_count, 0);
    check("async mis_idx", mis_idx, 0);
    @(negedge clk);
    reset = 1'b1;
    ceBefore = ceTotal;
    repeat (10) @(negedge clk);
    check("post_async ce_silent", ceTotal, ceBefore);
    check("post_async busy", busy, 0);
    // Length register was cleared by reset, so a bare start finishes at once.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("post_async len0 done", done, 1);
    check("post_async len0 ce", ceTotal, ceBefore);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
